// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a synchronous TX FIFO.
// Frames bytes onto tx at CLK_DIV pclk cycles per bit; flags baud ticks and frame completion.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic              tx_en,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              wr_ovf,
  output logic              tx,
  output logic              busy,
  output logic              baud,
  output logic              tx_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_nxt;
  logic [7:0]        shift, shift_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic              tx_nxt;
  logic              pop, push;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;

  assign push      = wr_en && !full;
  assign busy      = (state != IDLE);
  assign baud      = busy && (baud_cnt == CNT_W'(CLK_DIV - 1));
  assign tx_done   = (state == STOP) && baud;
  assign count_nxt = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // full/empty are registered from the next occupancy so they track count exactly
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      wr_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count  <= count_nxt;
      full   <= (count_nxt == (ADDR_W+1)'(FIFO_DEPTH));
      empty  <= (count_nxt == '0);
      wr_ovf <= wr_en && full;
    end
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    bit_idx_nxt  = bit_idx;
    tx_nxt       = tx;
    pop          = 1'b0;
    baud_cnt_nxt = (state == IDLE || baud) ? '0 : baud_cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        if (tx_en && !empty) begin
          pop         = 1'b1;
          shift_nxt   = mem[rd_ptr];
          bit_idx_nxt = '0;
          tx_nxt      = 1'b0;
          state_nxt   = START;
        end
      end
      START: begin
        if (baud) begin
          tx_nxt    = shift[0];
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (baud) begin
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            shift_nxt   = shift >> 1;
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = shift[1];
          end
        end
      end
      STOP: begin
        if (baud) begin
          if (tx_en && !empty) begin
            pop         = 1'b1;
            shift_nxt   = mem[rd_ptr];
            bit_idx_nxt = '0;
            tx_nxt      = 1'b0;
            state_nxt   = START;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      baud_cnt <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt_nxt;
      shift    <= shift_nxt;
      bit_idx  <= bit_idx_nxt;
      tx       <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed vectors and sequences plus randomized traffic,
// all checked every cycle against a frame-level reference model.
module tb_uart_tx_fifo;

  localparam int D     = 16;
  localparam int DEPTH = 8;

  logic       pclk, prstn, tx_en, wr_en;
  logic [7:0] wr_data;
  logic       full, empty, wr_ovf, tx, busy, baud, tx_done;
  logic [3:0] count;

  uart_tx_fifo #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH), .ADDR_W(3)) dut (
    .pclk(pclk), .prstn(prstn), .tx_en(tx_en), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .wr_ovf(wr_ovf), .tx(tx),
    .busy(busy), .baud(baud), .tx_done(tx_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int nbusy, ndone;

  // Reference model: FIFO contents as a queue, frame position as elapsed cycles (-1 = idle)
  logic [7:0] q[$];
  int         el;
  logic [7:0] cur;
  logic       m_ovf;

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      if (errors >= 40) begin
        summary();
        $finish;
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    el    = -1;
    cur   = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_update();
    bit full_pre, pop;
    if (!prstn) begin
      model_reset();
      return;
    end
    full_pre = (q.size() == DEPTH);
    pop = (q.size() > 0) && tx_en && (el < 0 || el == 10*D-1);
    if (el >= 0) el = (el == 10*D-1) ? (pop ? 0 : -1) : el + 1;
    else if (pop) el = 0;
    if (pop) cur = q.pop_front();
    if (wr_en && !full_pre) q.push_back(wr_data);
    m_ovf = wr_en && full_pre;
  endtask

  function automatic logic [31:0] model_vec();
    logic mtx;
    int   idx;
    if (el < 0) mtx = 1'b1;
    else begin
      idx = el / D;
      if (idx == 0)      mtx = 1'b0;
      else if (idx == 9) mtx = 1'b1;
      else               mtx = cur[idx-1];
    end
    return {21'd0, mtx, (el >= 0), (el >= 0) && (el % D == D-1), (el == 10*D-1),
            m_ovf, (q.size() == DEPTH), (q.size() == 0), 4'(q.size())};
  endfunction

  task automatic model_check();
    chk("outputs{tx,busy,baud,done,ovf,full,empty,count}",
        {21'd0, tx, busy, baud, tx_done, wr_ovf, full, empty, count}, model_vec());
  endtask

  task automatic step();
    @(posedge pclk);
    model_update();
    #1;
    model_check();
    nbusy += int'(busy);
    ndone += int'(tx_done);
  endtask

  task automatic do_reset(input int cycles);
    prstn = 1'b0;
    wr_en = 1'b0;
    model_reset();
    #1;
    model_check();
    chk("rst_tx", tx, 1);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    repeat (cycles) step();
    prstn = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy || !empty) begin
      step();
      n++;
      if (n > budget) begin
        chk("wait_idle_timeout", 1, 0);
        return;
      end
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  // Serial receiver: finds the start edge and samples each bit at mid-period
  task automatic rx_byte(output logic [7:0] b);
    int n = 0;
    b = '0;
    while (tx !== 1'b0) begin
      step();
      n++;
      if (n > 3000) begin
        chk("rx_timeout", 1, 0);
        return;
      end
    end
    repeat (D/2) step();
    for (int i = 0; i < 8; i++) begin
      repeat (D) step();
      b[i] = tx;
    end
    repeat (D) step();
    chk("rx_stop_bit", tx, 1);
  endtask

  typedef struct {
    logic       tx_en, wr_en;
    logic [7:0] data;
    logic       e_tx, e_busy;
    logic [3:0] e_count;
    logic       e_empty, e_full, e_ovf;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [7:0] b;
    logic [9:0] fr;
    bit burst;

    vt[0] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};

    nbusy = 0; ndone = 0;
    tx_en = 1'b0; wr_en = 1'b0; wr_data = '0; prstn = 1'b1;
    #2;
    do_reset(3);

    // Idle after reset
    tx_en = 1'b1;
    repeat (50) step();
    chk("idle_tx", tx, 1);

    // Directed vectors
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_en   = vt[i].tx_en;
      wr_en   = vt[i].wr_en;
      wr_data = vt[i].data;
      step();
      chk($sformatf("vec%0d", i), {tx, busy, count, empty, full, wr_ovf},
          {vt[i].e_tx, vt[i].e_busy, vt[i].e_count, vt[i].e_empty, vt[i].e_full, vt[i].e_ovf});
    end
    wr_en = 1'b0;
    // tx_en low mid-frame: current frame finishes, queued bytes stay put
    repeat (200) step();
    chk("txen_off_busy", busy, 0);
    chk("txen_off_count", count, 2);
    tx_en = 1'b1;
    wait_idle(1000);

    // Single byte 0xC5
    push(8'hC5);
    fr = {1'b1, 8'hC5, 1'b0};
    for (int k = 0; k < 10*D; k++) begin
      step();
      chk("c5_tx", tx, fr[k/D]);
      chk("c5_done", tx_done, (k == 10*D-1));
    end
    step();
    chk("c5_busy_after", busy, 0);

    // Back-to-back frames
    nbusy = 0; ndone = 0;
    push(8'h0D);
    push(8'hE9);
    push(8'hA1);
    wait_idle(1000);
    chk("b2b_done_count", ndone, 3);
    chk("b2b_busy_cycles", nbusy, 30*D);
    chk("b2b_empty", empty, 1);

    // Overflow with transmitter disabled
    tx_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push(8'(i));
      chk($sformatf("ovf_after_write%0d", i), wr_ovf, (i == 8));
    end
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 8);
    step();
    chk("ovf_pulse_end", wr_ovf, 0);
    tx_en = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      rx_byte(b);
      chk($sformatf("ovf_rx%0d", i), b, i);
    end
    wait_idle(1000);
    chk("ovf_drained", empty, 1);

    // Push during STOP-bit pop while full, then push+pop at count 3
    tx_en = 1'b0;
    for (int i = 0; i < 8; i++) push(8'($urandom));
    tx_en = 1'b1;
    step();
    push(8'h77);
    chk("pp_count8", count, 8);
    begin
      int n = 0;
      while (!tx_done && n < 400) begin step(); n++; end
      chk("pp_found_done", tx_done, 1);
    end
    push(8'h99);
    chk("pp_full_ovf", wr_ovf, 1);
    chk("pp_full_count", count, 7);
    begin
      int n = 0;
      while (!(tx_done && count == 4'd3) && n < 3000) begin step(); n++; end
      chk("pp_found_cnt3", {tx_done, count}, {1'b1, 4'd3});
    end
    push(8'h5A);
    chk("pp_cnt3_count", count, 3);
    chk("pp_cnt3_ovf", wr_ovf, 0);
    wait_idle(3000);

    // Reset during data bit 4 of 0xF0 with two bytes queued
    tx_en = 1'b0;
    push(8'hF0); push(8'h5A); push(8'h3C);
    tx_en = 1'b1;
    step();
    repeat (5*D + 8) step();
    chk("mid_busy", busy, 1);
    chk("mid_count", count, 2);
    do_reset(2);
    nbusy = 0;
    repeat (50) step();
    chk("post_rst_no_frame", nbusy, 0);
    push(8'hFF);
    push(8'h00);
    rx_byte(b);
    chk("loop_ff", b, 8'hFF);
    rx_byte(b);
    chk("loop_00", b, 8'h00);
    wait_idle(1000);

    // Randomized traffic
    burst = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (c % 700 == 0) burst = ~burst;
      tx_en   = ($urandom_range(0, 9) != 0);
      wr_en   = burst ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 1999) == 0) do_reset(1);
      else step();
    end
    wr_en = 1'b0;
    tx_en = 1'b1;
    wait_idle(3000);
    chk("final_empty", empty, 1);

    summary();
    $finish;
  end

endmodule
